winograd_conv_tiled: RTL

- Parametrised Winograd F(4x4,3x3) convolution engine.
- Takes an IMG_H x IMG_W signed image and a 3x3 kernel; produces a valid-mode (IMG_H-2) x (IMG_W-2) result.
- Tiles the image into a ceil-sized 6x6-tile grid with zero padding. Runs every tile through the shared tile_controller. Accumulates scaled tile results across calls for multi-channel convolution, then applies the final divide-by-576 serially.
- Sits between the matrix register file and the convolution command decoder.

---
 rtl/winograd_pkg.sv | 46 ++++
 rtl/div_const_576.sv | 17 +
 rtl/tile_controller.sv | 81 ++++++++
 rtl/winograd_conv_tiled.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared types and constants for the Winograd F(4x4,3x3) convolution slice.
// Transform matrices are integer-scaled so every tile result carries a x576 factor.
package winograd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_CLEAR,
        ST_WAIT,
        ST_WRITE,
        ST_DIVIDE,
        ST_FINISH
    } state_t;

    localparam int WINO_SCALE = 576;
    localparam int TILE_IN    = 6;
    localparam int TILE_OUT   = 4;
    localparam int K          = 3;

    localparam int BT [TILE_IN][TILE_IN] = '{
        '{4,  0, -5,  0, 1, 0},
        '{0, -4, -4,  1, 1, 0},
        '{0,  4, -4, -1, 1, 0},
        '{0, -2, -1,  2, 1, 0},
        '{0,  2, -1, -2, 1, 0},
        '{0,  4,  0, -5, 0, 1}
    };

    // G scaled by 24 to stay in integers
    localparam int GS [TILE_IN][K] = '{
        '{ 6,  0,  0},
        '{-4, -4, -4},
        '{-4,  4, -4},
        '{ 1,  2,  4},
        '{ 1, -2,  4},
        '{ 0,  0, 24}
    };

    localparam int AT [TILE_OUT][TILE_IN] = '{
        '{1, 1,  1, 1,  1, 0},
        '{0, 1, -1, 2, -2, 0},
        '{0, 1,  1, 4,  4, 0},
        '{0, 1, -1, 8, -8, 1}
    };

endpackage

// File: rtl/div_const_576.sv
// Signed divide of a scaled accumulator by 576, truncating toward zero.
// The quotient keeps only the low DATA_W bits; there is no saturation.
module div_const_576
    import winograd_pkg::*;
#(
    parameter int ACC_W  = 48,
    parameter int DATA_W = 32
) (
    input  logic signed [ACC_W-1:0]  dividend,
    output logic signed [DATA_W-1:0] quotient
);

    localparam logic signed [ACC_W-1:0] DIVISOR = ACC_W'(WINO_SCALE);

    assign quotient = DATA_W'(dividend / DIVISOR);

endmodule

// File: rtl/tile_controller.sv
// One 6x6 tile through the integer Winograd F(4x4,3x3) pipeline.
// done is a level: cleared by start, set once the x576 result is registered.
module tile_controller
    import winograd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] kernel_in [K][K],
    input  logic signed [DATA_W-1:0] tile_in [TILE_IN][TILE_IN],
    output logic signed [ACC_W-1:0]  result [TILE_OUT][TILE_OUT],
    output logic                     done
);

    logic signed [DATA_W-1:0] g_q [K][K];
    logic signed [DATA_W-1:0] d_q [TILE_IN][TILE_IN];
    logic                     pend;

    logic signed [ACC_W-1:0] gu [TILE_IN][K];
    logic signed [ACC_W-1:0] u  [TILE_IN][TILE_IN];
    logic signed [ACC_W-1:0] vt [TILE_IN][TILE_IN];
    logic signed [ACC_W-1:0] v  [TILE_IN][TILE_IN];
    logic signed [ACC_W-1:0] yt [TILE_OUT][TILE_IN];
    logic signed [ACC_W-1:0] y  [TILE_OUT][TILE_OUT];

    always_comb begin
        gu = '{default: '0};
        u  = '{default: '0};
        vt = '{default: '0};
        v  = '{default: '0};
        yt = '{default: '0};
        y  = '{default: '0};
        for (int i = 0; i < TILE_IN; i++)
            for (int j = 0; j < K; j++)
                for (int k = 0; k < K; k++)
                    gu[i][j] += ACC_W'(GS[i][k]) * ACC_W'(g_q[k][j]);
        for (int i = 0; i < TILE_IN; i++)
            for (int j = 0; j < TILE_IN; j++)
                for (int k = 0; k < K; k++)
                    u[i][j] += gu[i][k] * ACC_W'(GS[j][k]);
        for (int i = 0; i < TILE_IN; i++)
            for (int j = 0; j < TILE_IN; j++)
                for (int k = 0; k < TILE_IN; k++)
                    vt[i][j] += ACC_W'(BT[i][k]) * ACC_W'(d_q[k][j]);
        for (int i = 0; i < TILE_IN; i++)
            for (int j = 0; j < TILE_IN; j++)
                for (int k = 0; k < TILE_IN; k++)
                    v[i][j] += vt[i][k] * ACC_W'(BT[j][k]);
        for (int i = 0; i < TILE_OUT; i++)
            for (int j = 0; j < TILE_IN; j++)
                for (int k = 0; k < TILE_IN; k++)
                    yt[i][j] += ACC_W'(AT[i][k]) * (u[k][j] * v[k][j]);
        for (int i = 0; i < TILE_OUT; i++)
            for (int j = 0; j < TILE_OUT; j++)
                for (int k = 0; k < TILE_IN; k++)
                    y[i][j] += yt[i][k] * ACC_W'(AT[j][k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q    <= '{default: '0};
            d_q    <= '{default: '0};
            result <= '{default: '0};
            pend   <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            g_q  <= kernel_in;
            d_q  <= tile_in;
            pend <= 1'b1;
            done <= 1'b0;
        end else if (pend) begin
            result <= y;
            pend   <= 1'b0;
            done   <= 1'b1;
        end
    end

endmodule

// File: rtl/winograd_conv_tiled.sv
// Tiled valid-mode 3x3 convolution over a whole image using Winograd tiles.
// Scaled results accumulate across jobs; the /576 is applied serially at the end.
module winograd_conv_tiled
    import winograd_pkg::*;
#(
    parameter  int IMG_H  = 10,
    parameter  int IMG_W  = 12,
    parameter  int DATA_W = 32,
    parameter  int ACC_W  = 48,
    localparam int OUT_H  = IMG_H - 2,
    localparam int OUT_W  = IMG_W - 2,
    localparam int T_ROWS = (OUT_H + 3) / 4,
    localparam int T_COLS = (OUT_W + 3) / 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     accumulate,
    input  logic signed [DATA_W-1:0] image_in [IMG_H][IMG_W],
    input  logic signed [DATA_W-1:0] kernel_in [K][K],
    output logic signed [DATA_W-1:0] result_out [OUT_H][OUT_W],
    output logic                     busy,
    output logic                     done
);

    localparam int IW = $clog2(IMG_H + IMG_W) + 1;

    state_t                   state;
    logic [IW-1:0]            ti, tj, er, ec;
    logic signed [DATA_W-1:0] img_q [IMG_H][IMG_W];
    logic signed [DATA_W-1:0] ker_q [K][K];
    logic signed [ACC_W-1:0]  acc [OUT_H][OUT_W];
    logic signed [DATA_W-1:0] tile [TILE_IN][TILE_IN];
    logic signed [ACC_W-1:0]  tc_res [TILE_OUT][TILE_OUT];
    logic signed [DATA_W-1:0] div_q;
    logic                     tc_start, tc_done;
    logic                     accept, last_tile;

    assign accept    = start && (state == ST_IDLE || state == ST_FINISH);
    assign last_tile = (ti == IW'(T_ROWS - 1)) && (tj == IW'(T_COLS - 1));

    // Window past the image edge reads as zero padding
    always_comb begin
        tile = '{default: '0};
        for (int r = 0; r < TILE_IN; r++)
            for (int c = 0; c < TILE_IN; c++)
                if (int'(ti) * TILE_OUT + r < IMG_H &&
                    int'(tj) * TILE_OUT + c < IMG_W)
                    tile[r][c] = img_q[int'(ti) * TILE_OUT + r]
                                      [int'(tj) * TILE_OUT + c];
    end

    tile_controller #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_tc (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tc_start),
        .kernel_in(ker_q),
        .tile_in  (tile),
        .result   (tc_res),
        .done     (tc_done)
    );

    div_const_576 #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_div (
        .dividend(acc[er][ec]),
        .quotient(div_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            tc_start   <= 1'b0;
            ti         <= '0;
            tj         <= '0;
            er         <= '0;
            ec         <= '0;
            img_q      <= '{default: '0};
            ker_q      <= '{default: '0};
            acc        <= '{default: '0};
            result_out <= '{default: '0};
        end else begin
            tc_start <= 1'b0;
            done     <= 1'b0;
            if (accept) begin
                img_q <= image_in;
                ker_q <= kernel_in;
                if (!accumulate)
                    acc <= '{default: '0};
                ti    <= '0;
                tj    <= '0;
                busy  <= 1'b1;
                state <= ST_LOAD;
            end else begin
                case (state)
                    ST_LOAD: begin
                        tc_start <= 1'b1;
                        state    <= ST_WAIT_CLEAR;
                    end
                    ST_WAIT_CLEAR: if (!tc_done) state <= ST_WAIT;
                    ST_WAIT:       if (tc_done) state <= ST_WRITE;
                    ST_WRITE: begin
                        for (int r = 0; r < TILE_OUT; r++)
                            for (int c = 0; c < TILE_OUT; c++)
                                if (int'(ti) * TILE_OUT + r < OUT_H &&
                                    int'(tj) * TILE_OUT + c < OUT_W)
                                    acc[int'(ti) * TILE_OUT + r]
                                       [int'(tj) * TILE_OUT + c] <=
                                        acc[int'(ti) * TILE_OUT + r]
                                           [int'(tj) * TILE_OUT + c]
                                        + tc_res[r][c];
                        if (last_tile) begin
                            er    <= '0;
                            ec    <= '0;
                            state <= ST_DIVIDE;
                        end else begin
                            if (tj == IW'(T_COLS - 1)) begin
                                tj <= '0;
                                ti <= ti + IW'(1);
                            end else begin
                                tj <= tj + IW'(1);
                            end
                            state <= ST_LOAD;
                        end
                    end
                    ST_DIVIDE: begin
                        result_out[er][ec] <= div_q;
                        if (ec == IW'(OUT_W - 1)) begin
                            ec <= '0;
                            if (er == IW'(OUT_H - 1)) begin
                                er    <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_FINISH;
                            end else begin
                                er <= er + IW'(1);
                            end
                        end else begin
                            ec <= ec + IW'(1);
                        end
                    end
                    ST_FINISH: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
